// File: rtl/piano_note_scheduler.sv
// Chooses the note fed to the tone generator: the most recently pressed key in MANUAL, ROM playback in AUTO.
// Key and mode edges are registered, so a change sampled on one clock reaches the note on the next.
module piano_note_scheduler #(
  parameter int TICK_DIV = 16,
  parameter int GAP_CYC  = 2,
  parameter int SONG_LEN = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MODE,
  input  logic [7:0] sw,
  input  logic [3:0] song_note,
  input  logic [2:0] song_beats,
  output logic [4:0] song_addr,
  output logic [3:0] note,
  output logic       note_valid,
  output logic       auto_on,
  output logic       song_done
);

  localparam int CNT_MAX = (7 * TICK_DIV > GAP_CYC) ? 7 * TICK_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {MANUAL, A_LOAD, A_PLAY, A_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_sw_q, r_rise;
  logic          r_mode_q, r_mode_rise;
  logic [2:0]    r_key, w_key_nxt;
  logic [3:0]    r_man_note, w_man_nxt;
  logic [3:0]    r_play_note, w_play_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] w_beat_cyc;
  logic [4:0]    r_addr, w_addr_nxt;
  logic          r_done, w_done_nxt;
  logic [2:0]    w_rise_top, w_sw_top;
  logic          w_key_lost;

  // Highest set index = lowest pitch among simultaneous keys.
  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_rise_top = top_bit(r_rise);
  assign w_sw_top   = top_bit(r_sw_q);
  assign w_key_lost = (r_man_note == 4'd0) || !r_sw_q[r_key];
  assign w_beat_cyc = CW'(int'(song_beats) * TICK_DIV - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_man_nxt   = r_man_note;
    w_play_nxt  = r_play_note;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_done_nxt  = 1'b0;
    case (r_state)
      MANUAL: begin
        if (r_mode_rise) begin
          w_state_nxt = A_LOAD;
          w_addr_nxt  = 5'd0;
          w_man_nxt   = 4'd0;
        end else if (r_rise != 8'd0) begin
          w_key_nxt = w_rise_top;
          w_man_nxt = 4'd8 - {1'b0, w_rise_top};
        end else if (w_key_lost) begin
          w_key_nxt = w_sw_top;
          w_man_nxt = (r_sw_q != 8'd0) ? 4'd8 - {1'b0, w_sw_top} : 4'd0;
        end
      end
      A_LOAD: begin
        if (r_mode_rise) begin
          w_state_nxt = MANUAL;
          w_addr_nxt  = 5'd0;
        end else if (song_beats == 3'd0) begin
          w_state_nxt = MANUAL;
          w_addr_nxt  = 5'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = A_PLAY;
          w_play_nxt  = song_note;
          w_cnt_nxt   = w_beat_cyc;
        end
      end
      A_PLAY: begin
        if (r_mode_rise) begin
          w_state_nxt = MANUAL;
          w_addr_nxt  = 5'd0;
        end else if (r_cnt == '0) begin
          w_state_nxt = A_GAP;
          w_cnt_nxt   = CW'(GAP_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      A_GAP: begin
        if (r_mode_rise) begin
          w_state_nxt = MANUAL;
          w_addr_nxt  = 5'd0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_addr == 5'(SONG_LEN - 1)) begin
          w_state_nxt = MANUAL;
          w_addr_nxt  = 5'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = A_LOAD;
          w_addr_nxt  = r_addr + 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= MANUAL;
      r_sw_q      <= 8'd0;
      r_rise      <= 8'd0;
      r_mode_q    <= 1'b0;
      r_mode_rise <= 1'b0;
      r_key       <= 3'd0;
      r_man_note  <= 4'd0;
      r_play_note <= 4'd0;
      r_cnt       <= '0;
      r_addr      <= 5'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sw_q      <= sw;
      r_rise      <= sw & ~r_sw_q;
      r_mode_q    <= MODE;
      r_mode_rise <= MODE & ~r_mode_q;
      r_key       <= w_key_nxt;
      r_man_note  <= w_man_nxt;
      r_play_note <= w_play_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    note = 4'd0;
    if (r_state == MANUAL)      note = r_man_note;
    else if (r_state == A_PLAY) note = r_play_note;
  end

  assign note_valid = (note != 4'd0);
  assign auto_on    = (r_state != MANUAL);
  assign song_addr  = r_addr;
  assign song_done  = r_done;

endmodule
